// File: rtl/datapath_pkg.sv
// Shared datapath constants and the instruction-loader state type.
package datapath_pkg;
  localparam int ADDR_W = 12;
  localparam int INST_W = 19;

  typedef enum logic [3:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_B0, S_B1, S_B2, S_WRITE, S_TRAIL, S_DONE, S_ERR
  } ld_state_t;
endpackage

// File: rtl/inst_word_packer.sv
// Collects B0/B1/B2 of one instruction word and flags a B2 with nonzero upper bits.
module inst_word_packer (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          shift,
  input  logic                          last,
  input  logic [7:0]                    din,
  output logic [datapath_pkg::INST_W-1:0] word,
  output logic                          fmt_err
);
  logic [15:0] lo;
  logic [2:0]  hi;

  // B0 and B1 shift into lo; only the three live bits of B2 are kept.
  always_ff @(posedge clk) begin
    if (!reset) begin
      lo <= '0;
      hi <= '0;
    end else if (shift) begin
      if (last) hi <= din[2:0];
      else      lo <= {din, lo[15:8]};
    end
  end

  assign word    = {hi, lo};
  assign fmt_err = |din[7:3];
endmodule

// File: rtl/inst_mem_loader.sv
// Streams length-prefixed 3-byte instruction words into instruction memory and
// holds the core in reset until a load succeeds. Trailer checksum: INST_LOADER_CHECKSUM_EN.
module inst_mem_loader #(
  parameter int ADDR_W = datapath_pkg::ADDR_W,
  parameter int INST_W = datapath_pkg::INST_W,
  parameter int DEPTH  = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [INST_W-1:0] imem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);
  import datapath_pkg::*;

  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  ld_state_t   state, state_nx;
  logic [7:0]  len_lo;
  logic [15:0] n_words;
  logic [ADDR_W:0] cnt;
  logic        xfer, start_ok, fmt_err, trail_ok;
  logic [15:0] len_in;
  logic [INST_W-1:0] word;

  assign xfer     = byte_valid && byte_ready;
  assign start_ok = start && (state == S_IDLE || state == S_DONE || state == S_ERR);
  assign len_in   = {byte_data, len_lo};

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    byte_ready = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (start) state_nx = S_LEN_LO;
      S_LEN_LO: begin
        byte_ready = 1'b1;
        if (byte_valid) state_nx = S_LEN_HI;
      end
      S_LEN_HI: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          if ({1'b0, len_in} > DEPTH_L) state_nx = S_ERR;
          else if (len_in == 16'd0)     state_nx = S_TRAIL;
          else                          state_nx = S_B0;
        end
      end
      S_B0: begin
        byte_ready = 1'b1;
        if (byte_valid) state_nx = S_B1;
      end
      S_B1: begin
        byte_ready = 1'b1;
        if (byte_valid) state_nx = S_B2;
      end
      S_B2: begin
        byte_ready = 1'b1;
        if (byte_valid) state_nx = fmt_err ? S_ERR : S_WRITE;
      end
      S_WRITE: state_nx = (17'(cnt) + 17'd1 == {1'b0, n_words}) ? S_TRAIL : S_B0;
      S_TRAIL: begin
        byte_ready = 1'b1;
        if (byte_valid) state_nx = trail_ok ? S_DONE : S_ERR;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt     <= '0;
      len_lo  <= '0;
      n_words <= '0;
    end else begin
      if (start_ok)              cnt <= '0;
      else if (state == S_WRITE) cnt <= cnt + 1'b1;
      if (state == S_LEN_LO && xfer) len_lo  <= byte_data;
      if (state == S_LEN_HI && xfer) n_words <= len_in;
    end
  end

`ifdef INST_LOADER_CHECKSUM_EN
  logic [7:0] csum;
  // Covers length and payload; the trailer itself is what gets compared.
  always_ff @(posedge clk) begin
    if (!reset)                        csum <= '0;
    else if (start_ok)                 csum <= '0;
    else if (xfer && state != S_TRAIL) csum <= csum ^ byte_data;
  end
  assign trail_ok = (byte_data == csum);
`else
  assign trail_ok = 1'b1;
`endif

  inst_word_packer u_packer (
    .clk     (clk),
    .reset   (reset),
    .shift   (xfer && (state == S_B0 || state == S_B1 || state == S_B2)),
    .last    (state == S_B2),
    .din     (byte_data),
    .word    (word),
    .fmt_err (fmt_err)
  );

  assign imem_we    = (state == S_WRITE);
  assign imem_waddr = cnt[ADDR_W-1:0];
  assign imem_wdata = word;
  assign word_count = cnt;
  assign busy       = (state == S_LEN_LO || state == S_LEN_HI || state == S_B0 ||
                       state == S_B1 || state == S_B2 || state == S_WRITE || state == S_TRAIL);
  assign done       = (state == S_DONE);
  assign err        = (state == S_ERR);
  assign cpu_reset  = (state != S_DONE);
endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader: stream-level model predicts writes and outcome.
module tb_inst_mem_loader;
  logic        clk = 1'b0, reset = 1'b0, start = 1'b0, byte_valid = 1'b0;
  logic [7:0]  byte_data = '0;
  logic        byte_ready, imem_we, cpu_reset, busy, done, err;
  logic [11:0] imem_waddr;
  logic [18:0] imem_wdata;
  logic [12:0] word_count;

`ifdef INST_LOADER_CHECKSUM_EN
  localparam bit CKS = 1'b1;
`else
  localparam bit CKS = 1'b0;
`endif

  inst_mem_loader dut (
    .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .imem_we(imem_we),
    .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .cpu_reset(cpu_reset),
    .busy(busy), .done(done), .err(err), .word_count(word_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct { int addr; logic [18:0] data; } wr_t;
  wr_t exp_wr[$];
  wr_t w;
  int  exp_nwr, exp_wc;
  bit  exp_ok;

  // Predicts writes, final word count and pass/fail from the byte stream alone.
  function automatic void model(input logic [7:0] s[$]);
    int n;
    logic [7:0] x;
    exp_wr.delete();
    exp_ok = 1'b0;
    exp_wc = 0;
    n = int'({s[1], s[0]});
    x = s[0] ^ s[1];
    if (n > 4096) return;
    for (int k = 0; k < n; k++) begin
      if (s[4+3*k][7:3] != 5'd0) begin
        exp_wc = k;
        return;
      end
      exp_wr.push_back('{addr: k, data: {s[4+3*k][2:0], s[3+3*k], s[2+3*k]}});
      x = x ^ s[2+3*k] ^ s[3+3*k] ^ s[4+3*k];
    end
    exp_wc = n;
    exp_ok = !CKS || (s[2+3*n] == x);
  endfunction

  function automatic logic [7:0] xsum(input logic [7:0] s[$]);
    logic [7:0] x = '0;
    for (int i = 0; i < s.size() - 1; i++) x ^= s[i];
    return x;
  endfunction

  bit          mon_on = 1'b0, exp_we = 1'b0;
  int          xfer_idx = 0;
  logic [18:0] mem [0:7];
  logic [18:0] mem_gap [0:1];

  // Write timing/content check every cycle while a load is being followed.
  always @(negedge clk) begin
    if (mon_on) begin
      chk("we_timing", imem_we, exp_we);
      if (imem_we) begin
        chk("ready_in_write", byte_ready, 1'b0);
        if (exp_wr.size() > 0) begin
          w = exp_wr.pop_front();
          chk("waddr", imem_waddr, w.addr);
          chk("wdata", imem_wdata, w.data);
        end
        if (imem_waddr < 12'd8) mem[imem_waddr[2:0]] = imem_wdata;
      end
      exp_we = byte_valid && byte_ready && xfer_idx >= 4 &&
               (xfer_idx - 4) % 3 == 0 && (xfer_idx - 4) / 3 < exp_nwr;
      if (byte_valid && byte_ready) xfer_idx++;
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps, output bit got);
    int t = 0;
    if (gaps) begin
      byte_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    byte_valid = 1'b1;
    byte_data  = b;
    got = 1'b0;
    do begin
      @(negedge clk);
      got = byte_ready;
      @(posedge clk); #1;
      t++;
    end while (!got && t < 50);
    byte_valid = 1'b0;
    chk("byte_accept", got, 1'b1);
  endtask

  task automatic begin_load(input logic [7:0] s[$]);
    model(s);
    exp_nwr  = exp_wr.size();
    xfer_idx = 0;
    exp_we   = 1'b0;
    mon_on   = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run_load(input logic [7:0] s[$], input bit gaps, input bit poke);
    bit got;
    int t = 0;
    begin_load(s);
    foreach (s[i]) begin
      if (poke && i == 5) start = 1'b1;
      send_byte(s[i], gaps, got);
      start = 1'b0;
      if (!got) break;
    end
    while (!(done || err) && t < 100) begin @(posedge clk); #1; t++; end
    @(negedge clk);
    chk("done", done, exp_ok);
    chk("err", err, !exp_ok);
    chk("cpu_reset", cpu_reset, !exp_ok);
    chk("busy", busy, 1'b0);
    chk("word_count", word_count, exp_wc);
    chk("writes_left", exp_wr.size(), 0);
    @(posedge clk); #1 mon_on = 1'b0;
  endtask

  task automatic reset_checks();
    @(negedge clk);
    chk("rst_ready", byte_ready, 1'b0);
    chk("rst_we", imem_we, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_waddr", imem_waddr, 0);
    chk("rst_wdata", imem_wdata, 0);
    chk("rst_wc", word_count, 0);
    chk("rst_cpu_reset", cpu_reset, 1'b1);
  endtask

  logic [7:0] s_nom[$], s_zero[$], s_over[$], s_fmt[$], s_bad[$];

  initial begin
    bit got;
    s_nom  = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h05, 8'hFF, 8'hFF, 8'h07, 8'h26};
    s_bad  = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h05, 8'hFF, 8'hFF, 8'h07, 8'h2F};
    s_zero = '{8'h00, 8'h00, 8'h00};
    s_over = '{8'h01, 8'h10};
    s_fmt  = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h05, 8'h11, 8'h22, 8'h08};

    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    reset_checks();

    // Pin the model against hand-worked values of the nominal stream.
    model(s_nom);
    chk("model_w0", exp_wr[0].data, 19'h51234);
    chk("model_w1", exp_wr[1].data, 19'h7FFFF);
    chk("model_xor", xsum(s_nom), 8'h26);
    model(s_over);
    chk("model_over_wr", exp_wr.size(), 0);

    run_load(s_nom, 1'b1, 1'b0);
    mem_gap[0] = mem[0];
    mem_gap[1] = mem[1];
    mem[0] = '0;
    mem[1] = '0;
    run_load(s_nom, 1'b0, 1'b0);
    chk("mem0_same", mem[0], mem_gap[0]);
    chk("mem1_same", mem[1], mem_gap[1]);
    chk("mem0_lit", mem[0], 19'h51234);
    chk("mem1_lit", mem[1], 19'h7FFFF);

    run_load(s_zero, 1'b1, 1'b0);
    run_load(s_over, 1'b0, 1'b0);
    run_load(s_fmt, 1'b1, 1'b0);
    run_load(s_nom, 1'b1, 1'b1);

    // Reset right after the first word's write cycle, then reload from idle.
    mem[0] = '0;
    begin_load(s_nom);
    for (int i = 0; i < 5; i++) send_byte(s_nom[i], 1'b0, got);
    @(posedge clk); #1 mon_on = 1'b0;
    chk("mid_mem0", mem[0], 19'h51234);
    reset = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    reset_checks();
    run_load(s_nom, 1'b0, 1'b0);

    run_load(s_bad, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
